// File: rtl/dlf_pkg.sv
// Shared types and helpers for the gear-shifting digital loop filter.
package dlf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2
   } dlf_state_e;

   // Clamp a wide signed value into the two's-complement range of a w-bit word.
   function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/dlf_iir_stage.sv
// One-pole IIR section y += (x - y) >>> shift, advancing only on valid samples.
module dlf_iir_stage
   import dlf_pkg::*;
#(
   parameter int W = 13
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                vld_i,
   input  logic signed [W-1:0] x_i,
   input  logic [3:0]          shift_i,
   output logic signed [W-1:0] y_o,
   output logic                vld_o
);

   logic signed [W-1:0] y_q, y_d;
   logic                vld_q;
   logic signed [W:0]   diff_s;
   logic signed [W:0]   step_s;
   logic signed [W:0]   sum_s;

   // One guard bit keeps x - y exact; the result lies between y and x so it fits W bits.
   always_comb begin
      diff_s = {x_i[W-1], x_i} - {y_q[W-1], y_q};
      step_s = diff_s >>> shift_i;
      sum_s  = {y_q[W-1], y_q} + step_s;
      y_d    = sum_s[W-1:0];
   end

   // Filter state and valid delay.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         y_q   <= {W{1'b0}};
         vld_q <= 1'b0;
      end else begin
         vld_q <= vld_i;
         if (vld_i) begin
            y_q <= y_d;
         end
      end
   end

   logic unused_s;
   assign unused_s = sum_s[W];
   assign y_o      = y_q;
   assign vld_o    = vld_q;

endmodule

// File: rtl/digital_loop_filter_gear.sv
// Gear-shifting PI loop filter with TDC strobe divider.
// Optional DLF_IIR_EN inserts two IIR pre-filter stages (latency 3 -> 5 cycles).
module digital_loop_filter_gear
   import dlf_pkg::*;
#(
   parameter int IN_W   = 5,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16,
   parameter int ACC_W  = 28,
   parameter int FRAC_W = 8,
   parameter int NGEARS = 3,
   parameter int DIV    = 4,
   localparam int GW    = (NGEARS > 1) ? $clog2(NGEARS) : 1
) (
   input  logic                     sys_clk,
   input  logic                     por_rst,
   input  logic                     dlf_en,
   input  logic                     dlf_hold,
   input  logic [IN_W-1:0]          tdc_dout,
   input  logic [NGEARS*COEF_W-1:0] dlf_kp,
   input  logic [NGEARS*COEF_W-1:0] dlf_ki,
   input  logic [15:0]              dlf_gear_len,
   input  logic [3:0]               dlf_iir_shift,
   output logic                     clk_tdc,
   output logic [OUT_W-1:0]         dlf_out,
   output logic                     dlf_out_vld,
   output logic [GW-1:0]            dlf_gear
);

   localparam int CW = $clog2(DIV);
   localparam int PW = IN_W + COEF_W;

   logic [CW-1:0]             div_q, div_d;
   logic                      tdc_q, tdc_d;
   logic signed [IN_W-1:0]    err_q;
   logic                      s1_vld_q;
   logic signed [IN_W-1:0]    pi_err_s;
   logic                      pi_vld_s;
   dlf_state_e                state_q, state_d;
   logic [GW-1:0]             gear_q, gear_d;
   logic [15:0]               gcnt_q, gcnt_d;
   logic signed [COEF_W-1:0]  kp_sel_s, ki_sel_s;
   logic signed [63:0]        e_w, prop_w, acc_w, out_w;
   logic signed [PW-1:0]      prop_q;
   logic signed [ACC_W-1:0]   acc_q;
   logic                      s2_vld_q;
   logic signed [OUT_W-1:0]   out_q;
   logic                      vld_q;
   logic                      unused_s;

   // Strobe divider: free-runs while enabled, parked at zero otherwise.
   always_comb begin
      if (!dlf_en) begin
         div_d = {CW{1'b0}};
      end else if (div_q == CW'(DIV - 1)) begin
         div_d = {CW{1'b0}};
      end else begin
         div_d = div_q + CW'(1);
      end
      tdc_d = dlf_en && (div_d == CW'(DIV - 1));
   end

   // Divider and strobe registers.
   always_ff @(posedge sys_clk) begin
      if (por_rst) begin
         div_q <= {CW{1'b0}};
         tdc_q <= 1'b0;
      end else begin
         div_q <= div_d;
         tdc_q <= tdc_d;
      end
   end

   // Capture the phase error on the strobe.
   always_ff @(posedge sys_clk) begin
      if (por_rst) begin
         err_q    <= {IN_W{1'b0}};
         s1_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= tdc_q && dlf_en;
         if (tdc_q && dlf_en) begin
            err_q <= tdc_dout;
         end
      end
   end

`ifdef DLF_IIR_EN
   localparam int IW = IN_W + FRAC_W;
   logic signed [IW-1:0] x0_s, y1_s, y2_s;
   logic                 v1_s, v2_s;

   assign x0_s = {err_q, {FRAC_W{1'b0}}};

   dlf_iir_stage #(.W(IW)) u_iir1 (
      .clk_i(sys_clk), .rst_i(por_rst), .clr_i(!dlf_en), .vld_i(s1_vld_q),
      .x_i(x0_s), .shift_i(dlf_iir_shift), .y_o(y1_s), .vld_o(v1_s)
   );
   dlf_iir_stage #(.W(IW)) u_iir2 (
      .clk_i(sys_clk), .rst_i(por_rst), .clr_i(!dlf_en), .vld_i(v1_s),
      .x_i(y1_s), .shift_i(dlf_iir_shift), .y_o(y2_s), .vld_o(v2_s)
   );

   // Dropping the fraction bits is the arithmetic shift back to error units.
   assign pi_err_s = y2_s[IW-1:FRAC_W];
   assign pi_vld_s = v2_s;
   assign unused_s = ^{prop_w[63:PW], acc_w[63:ACC_W], out_w[63:OUT_W], y2_s[FRAC_W-1:0]};
`else
   assign pi_err_s = err_q;
   assign pi_vld_s = s1_vld_q;
   assign unused_s = ^{prop_w[63:PW], acc_w[63:ACC_W], out_w[63:OUT_W], dlf_iir_shift};
`endif

   // PI arithmetic at full precision, saturated to each destination width.
   always_comb begin
      kp_sel_s = dlf_kp[gear_q*COEF_W +: COEF_W];
      ki_sel_s = dlf_ki[gear_q*COEF_W +: COEF_W];
      e_w      = 64'(pi_err_s);
      prop_w   = (e_w * 64'(kp_sel_s)) >>> FRAC_W;
      acc_w    = sat_s64(64'(acc_q) + e_w * 64'(ki_sel_s), ACC_W);
      out_w    = sat_s64(64'(prop_q) + (64'(acc_q) >>> FRAC_W), OUT_W);
   end

   // Proportional term and integrator; acc_q here is already this sample's acc_new.
   always_ff @(posedge sys_clk) begin
      if (por_rst || !dlf_en) begin
         prop_q   <= {PW{1'b0}};
         acc_q    <= {ACC_W{1'b0}};
         s2_vld_q <= 1'b0;
      end else begin
         s2_vld_q <= pi_vld_s;
         if (pi_vld_s) begin
            prop_q <= prop_w[PW-1:0];
            if (!dlf_hold) begin
               acc_q <= acc_w[ACC_W-1:0];
            end
         end
      end
   end

   // Output register keeps its last value when a sample is dropped.
   always_ff @(posedge sys_clk) begin
      if (por_rst) begin
         out_q <= {OUT_W{1'b0}};
         vld_q <= 1'b0;
      end else begin
         vld_q <= s2_vld_q && dlf_en;
         if (s2_vld_q && dlf_en) begin
            out_q <= out_w[OUT_W-1:0];
         end
      end
   end

   // Gear FSM: advances alongside the integrator so a new gear applies from the next strobe.
   always_comb begin
      state_d = state_q;
      gear_d  = gear_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         IDLE: begin
            gear_d = {GW{1'b0}};
            gcnt_d = 16'd0;
            if (dlf_en) begin
               state_d = (NGEARS == 1) ? TRACK : ACQ;
            end else begin
               state_d = IDLE;
            end
         end
         ACQ: begin
            if (!dlf_en) begin
               state_d = IDLE;
               gear_d  = {GW{1'b0}};
               gcnt_d  = 16'd0;
            end else if (pi_vld_s && !dlf_hold) begin
               if (dlf_gear_len == 16'd0) begin
                  state_d = TRACK;
                  gear_d  = GW'(NGEARS - 1);
                  gcnt_d  = 16'd0;
               end else if (gcnt_q == dlf_gear_len - 16'd1) begin
                  gcnt_d = 16'd0;
                  gear_d = gear_q + GW'(1);
                  if (gear_q + GW'(1) == GW'(NGEARS - 1)) begin
                     state_d = TRACK;
                  end else begin
                     state_d = ACQ;
                  end
               end else begin
                  gcnt_d = gcnt_q + 16'd1;
               end
            end else begin
               state_d = ACQ;
            end
         end
         TRACK: begin
            if (!dlf_en) begin
               state_d = IDLE;
               gear_d  = {GW{1'b0}};
               gcnt_d  = 16'd0;
            end else begin
               gear_d = GW'(NGEARS - 1);
            end
         end
         default: begin
            state_d = IDLE;
            gear_d  = {GW{1'b0}};
            gcnt_d  = 16'd0;
         end
      endcase
   end

   // FSM state, gear and gear counter.
   always_ff @(posedge sys_clk) begin
      if (por_rst) begin
         state_q <= IDLE;
         gear_q  <= {GW{1'b0}};
         gcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         gear_q  <= gear_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign clk_tdc     = tdc_q;
   assign dlf_out     = out_q;
   assign dlf_out_vld = vld_q;
   assign dlf_gear    = gear_q;

endmodule

// File: tb/tb_digital_loop_filter_gear.sv
// Scoreboard bench for digital_loop_filter_gear (default build, DIV=4, NGEARS=3).
module tb_digital_loop_filter_gear;

   logic        sys_clk = 1'b0;
   logic        por_rst, dlf_en, dlf_hold;
   logic [4:0]  tdc_dout;
   logic [47:0] dlf_kp, dlf_ki;
   logic [15:0] dlf_gear_len;
   logic [3:0]  dlf_iir_shift;
   logic        clk_tdc, dlf_out_vld;
   logic [15:0] dlf_out;
   logic [1:0]  dlf_gear;

   always #5 sys_clk = ~sys_clk;

   digital_loop_filter_gear dut (
      .sys_clk(sys_clk), .por_rst(por_rst), .dlf_en(dlf_en), .dlf_hold(dlf_hold),
      .tdc_dout(tdc_dout), .dlf_kp(dlf_kp), .dlf_ki(dlf_ki), .dlf_gear_len(dlf_gear_len),
      .dlf_iir_shift(dlf_iir_shift), .clk_tdc(clk_tdc), .dlf_out(dlf_out),
      .dlf_out_vld(dlf_out_vld), .dlf_gear(dlf_gear)
   );

   typedef struct { int out; int gear; } exp_t;
   exp_t sb_q[$];

   int total = 0;
   int bad   = 0;

   longint m_acc  = 0;
   longint m_kp   = 0;
   longint m_ki   = 0;
   int     m_len  = 4;
   int     m_gear = 0;
   int     m_gcnt = 0;

   function automatic longint sat(input longint v, input int w);
      longint hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      longint lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Reference PI/gear behaviour for one strobe.
   function automatic void model_step(input int err, input bit hold, output int out, output int gear);
      longint p;
      p = (longint'(err) * m_kp) >>> 8;
      if (!hold) begin
         m_acc = sat(m_acc + longint'(err) * m_ki, 28);
         if (m_gear < 2) begin
            if (m_len == 0) begin
               m_gear = 2;
            end else if (m_gcnt == m_len - 1) begin
               m_gcnt = 0;
               m_gear = m_gear + 1;
            end else begin
               m_gcnt = m_gcnt + 1;
            end
         end
      end
      out  = int'(sat(p + (m_acc >>> 8), 16));
      gear = m_gear;
   endfunction

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic wait_tdc();
      int n = 0;
      while (clk_tdc !== 1'b1 && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL strobe_timeout: got no clk_tdc within %0d cycles, expected one", n);
      end
   endtask

   // Issue one sample: drive inputs, push the expectation, step through to the vld cycle.
   task automatic do_sample(input int err, input bit hold, input bit hand, input int h_out, input int h_gear);
      int mo, mg;
      exp_t e;
      tdc_dout = 5'(err);
      dlf_hold = hold;
      model_step(err, hold, mo, mg);
      e.out  = hand ? h_out  : mo;
      e.gear = hand ? h_gear : mg;
      sb_q.push_back(e);
      wait_tdc();
      repeat (3) @(negedge sys_clk);
   endtask

   logic [2:0] tdc_hist = 3'b000;
   int         since    = -1;

   // Monitor: pops the scoreboard on every dlf_out_vld and checks strobe spacing.
   always @(negedge sys_clk) begin
      exp_t e;
      if (dlf_out_vld === 1'b1) begin
         check("vld_latency", int'(tdc_hist[2]), 1);
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_vld: got dlf_out=%0d with empty scoreboard, expected no pulse", $signed(dlf_out));
         end else begin
            e = sb_q.pop_front();
            check("dlf_out", int'($signed(dlf_out)), e.out);
            check("dlf_gear", int'(dlf_gear), e.gear);
         end
      end
      if (por_rst || !dlf_en) begin
         since = -1;
      end else if (clk_tdc === 1'b1) begin
         if (since >= 0) check("tdc_period", since + 1, 4);
         since = 0;
      end else if (since >= 0) begin
         since++;
      end
      tdc_hist = {tdc_hist[1:0], clk_tdc};
   end

   initial begin
      por_rst = 1'b1; dlf_en = 1'b0; dlf_hold = 1'b0; tdc_dout = 5'd0;
      dlf_kp = 48'd0; dlf_ki = 48'd0; dlf_gear_len = 16'd4; dlf_iir_shift = 4'd2;
      repeat (3) @(negedge sys_clk);
      check("rst_clk_tdc", int'(clk_tdc), 0);
      check("rst_out", int'(dlf_out), 0);
      check("rst_vld", int'(dlf_out_vld), 0);
      check("rst_gear", int'(dlf_gear), 0);
      por_rst = 1'b0;

      // Basic PI: err=+1, kp=ki=1.0 in every gear; out = samples + 1.
      dlf_kp = {3{16'd256}}; dlf_ki = {3{16'd256}};
      m_kp = 256; m_ki = 256; m_len = 4;
      dlf_en = 1'b1;
      for (int k = 1; k <= 5; k++) do_sample(1, 1'b0, 1'b1, k + 1, (k >= 4) ? 1 : 0);
      // Hold: acc frozen at 5, gear counter paused mid-gear-1.
      for (int k = 0; k < 5; k++) do_sample(1, 1'b1, 1'b1, 6, 1);
      for (int k = 6; k <= 10; k++) do_sample(1, 1'b0, 1'b1, k + 1, (k >= 8) ? 2 : 1);

      // Enable drops with a sample in flight: no pulse, output held, back to IDLE.
      tdc_dout = 5'd3;
      wait_tdc();
      dlf_en = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge sys_clk);
         check("drop_no_vld", int'(dlf_out_vld), 0);
      end
      check("drop_out_held", int'($signed(dlf_out)), 11);
      check("drop_gear_idle", int'(dlf_gear), 0);
      m_acc = 0; m_gear = 0; m_gcnt = 0;

      // Saturation toward both rails.
      dlf_kp = {3{16'd32767}}; dlf_ki = {3{16'd32767}};
      m_kp = 32767; m_ki = 32767;
      dlf_en = 1'b1;
      for (int k = 0; k < 64; k++) do_sample(15, 1'b0, 1'b0, 0, 0);
      check("sat_pos", int'($signed(dlf_out)), 32767);
      for (int k = 0; k < 80; k++) do_sample(-16, 1'b0, 1'b0, 0, 0);
      check("sat_neg", int'($signed(dlf_out)), -32768);
      check("track_gear", int'(dlf_gear), 2);

      // Mid-run reset overrides the enable.
      tdc_dout = 5'd7;
      por_rst = 1'b1;
      @(negedge sys_clk);
      check("mrst_clk_tdc", int'(clk_tdc), 0);
      check("mrst_out", int'(dlf_out), 0);
      check("mrst_vld", int'(dlf_out_vld), 0);
      check("mrst_gear", int'(dlf_gear), 0);
      por_rst = 1'b0;
      dlf_en  = 1'b0;
      repeat (4) @(negedge sys_clk);
      check("leftover_expect", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
